laser_cover_scorer: RTL and testbench
=====================================

// Module: laser_cover_scorer
// PURPOSE
//  Downstream checker for the two-circle laser placement engine. Snoops the 40-point
//  X/Y load stream into ping-pong banks; on the engine's DONE pulse latches C1/C2 centres.
//  Re-scores the completed bank against both circles and reports per-circle, overlap and
//  union hit counts over a valid/ready result port, while the next set loads.
// PARAMETERS
//  NPTS   40  points per data set
//  CW     4   coordinate width (grid 0..15)
//  RSQ    16  squared radius; hit when dx*dx+dy*dy <= RSQ
// PORTS
//  CLK        in   1  clock, rising edge
//  RST_N      in   1  asynchronous active-low reset
//  IN_VALID   in   1  X/Y carry a point this cycle
//  X, Y       in   4  point coordinates (same bus the engine samples)
//  DONE       in   1  one-cycle pulse from the engine; C1X..C2Y are final
//  C1X,C1Y    in   4  circle-1 centre
//  C2X,C2Y    in   4  circle-2 centre
//  RES_VALID  out  1  result registers valid
//  RES_READY  in   1  consumer accepts result
//  COV_C1     out  6  points inside circle 1
//  COV_C2     out  6  points inside circle 2
//  COV_BOTH   out  6  points inside both circles
//  COV_TOTAL  out  6  points inside at least one circle; COV_C1+COV_C2-COV_BOTH
//  ERR        out  1  sticky protocol error
// BEHAVIOUR
//  Reset: all outputs 0; wr_bank=0; both banks marked empty; FSM in IDLE; ERR=0.
//  Load: each IN_VALID cycle writes {X,Y} to bank[wr_bank][wr_cnt]; wr_cnt 0..NPTS-1.
//   At wr_cnt==NPTS-1, the current bank is marked full, wr_bank toggles, and wr_cnt=0.
//   Point 41 therefore lands in the other bank at index 0.
//   Writing into a bank still marked full, because its scoring is not done, sets ERR.
//   That write is still performed.
//  FSM: IDLE -> SCORE -> HOLD -> IDLE.
//   IDLE: DONE=1 with a full bank -> latch centres, rd_bank = most recently filled bank,
//    idx=0, clear counters, go to SCORE. DONE=1 with no full bank -> ERR=1, stay in IDLE.
//   SCORE: one point per cycle for exactly NPTS cycles, idx 0..NPTS-1.
//    Counters update registered. After idx==NPTS-1: rd_bank marked empty, go to HOLD.
//   HOLD: RES_VALID=1; outputs stable until RES_READY=1. The transfer cycle returns
//    to IDLE, RES_VALID drops next cycle.
//  Latency: DONE at cycle t -> RES_VALID at t+NPTS+1 (41 cycles), if RES_READY is tied high.
//  DONE outside IDLE (SCORE/HOLD): ERR=1, pulse ignored; the current result is unaffected.
//  DONE and a bank-full event in the same cycle: the bank that just filled counts as full.
//  Arithmetic: |dx|,|dy| as 4-bit unsigned abs diff; squares 8-bit; sum 9-bit.
//   Compare <= RSQ with no truncation. Counters 6 bits, saturate-free (max 40).
//  ERR clears only on reset. Mid-operation reset: immediate, discards banks and result.
// STRUCTURE
//  Package laser_pkg: NPTS, CW, RSQ, CNT_W=6, FSM state enum {IDLE,SCORE,HOLD}.
//  Sub-module circle_hit: combinational (px,py,cx,cy) -> hit.
//   Two instances, one per circle, both fed the same point.
//  Banks: 2 x NPTS x 8-bit register arrays; a one-hot full flag per bank.
// TESTING
//  1. Load 40 points all at (8,8). DONE with C1=(8,8), C2=(0,0).
//     -> C1=40, C2=0, BOTH=0, TOTAL=40, latency 41 cycles.
//  2. Points (0..39 mod 16, 0). C1=(2,0), C2=(6,0).
//     -> compare hand/golden counts; BOTH covers x=2..6; TOTAL=C1+C2-BOTH.
//  3. Boundary: a point at distance exactly 4, (4,0) vs centre (0,0) -> hit.
//     (3,3) vs (0,0) -> miss (18>16). (15,15) vs (15,15) -> hit.
//  4. DONE before any full bank -> ERR=1, RES_VALID stays 0. DONE during SCORE -> ERR=1;
//     the running result is unchanged.
//  5. RES_READY held low 100 cycles in HOLD -> outputs stable. A second set loads into the
//     other bank meanwhile, with no ERR. Release READY, then DONE -> second result correct.
//  6. Assert RST_N low mid-SCORE -> all outputs 0 asynchronously; the next full sequence
//     scores correctly.

Source files
------------

// File: rtl/laser_pkg.sv
// Shared sizing constants and FSM state type for the laser cover scorer.
package laser_pkg;

   localparam int unsigned NPTS  = 40;  // points per data set
   localparam int unsigned CW    = 4;   // coordinate width, grid 0..15
   localparam int unsigned RSQ   = 16;  // squared radius, inclusive
   localparam int unsigned CNT_W = 6;   // hit counter width (max value 40)

   typedef enum logic [1:0] {
      IDLE,
      SCORE,
      HOLD
   } state_e;

endpackage

// File: rtl/laser_cover_scorer_if.sv
// Load stream, centre snoop and result handshake bundled for the scorer.
interface laser_cover_scorer_if;
   import laser_pkg::*;

   logic             in_valid;
   logic [CW-1:0]    x;
   logic [CW-1:0]    y;
   logic             done;
   logic [CW-1:0]    c1x;
   logic [CW-1:0]    c1y;
   logic [CW-1:0]    c2x;
   logic [CW-1:0]    c2y;
   logic             res_valid;
   logic             res_ready;
   logic [CNT_W-1:0] cov_c1;
   logic [CNT_W-1:0] cov_c2;
   logic [CNT_W-1:0] cov_both;
   logic [CNT_W-1:0] cov_total;
   logic             err;

   // Producer / consumer side (engine plus result sink)
   modport master (
      output in_valid, x, y, done, c1x, c1y, c2x, c2y, res_ready,
      input  res_valid, cov_c1, cov_c2, cov_both, cov_total, err
   );

   // Scorer side
   modport slave (
      input  in_valid, x, y, done, c1x, c1y, c2x, c2y, res_ready,
      output res_valid, cov_c1, cov_c2, cov_both, cov_total, err
   );

endinterface

// File: rtl/circle_hit.sv
// Combinational point-in-circle test: hit when dx*dx + dy*dy <= RSQ.
module circle_hit
   import laser_pkg::*;
(
   input  logic [CW-1:0] px,
   input  logic [CW-1:0] py,
   input  logic [CW-1:0] cx,
   input  logic [CW-1:0] cy,
   output logic          hit
);

   localparam logic [2*CW:0] RSQ_W = (2*CW+1)'(RSQ);

   logic [CW-1:0]   dx;
   logic [CW-1:0]   dy;
   logic [2*CW-1:0] sq_x;
   logic [2*CW-1:0] sq_y;
   logic [2*CW:0]   dist_sq;

   // Unsigned abs difference, full-width squares and sum so nothing truncates
   always_comb begin
      dx      = (px >= cx) ? (px - cx) : (cx - px);
      dy      = (py >= cy) ? (py - cy) : (cy - py);
      sq_x    = {{CW{1'b0}}, dx} * {{CW{1'b0}}, dx};
      sq_y    = {{CW{1'b0}}, dy} * {{CW{1'b0}}, dy};
      dist_sq = {1'b0, sq_x} + {1'b0, sq_y};
      hit     = (dist_sq <= RSQ_W);
   end

endmodule

// File: rtl/laser_cover_scorer.sv
// Snoops the point stream into ping-pong banks and, on DONE, re-scores the
// completed bank against both circles while the next set keeps loading.
module laser_cover_scorer
   import laser_pkg::*;
(
   input logic                 clk,
   input logic                 rst_n,
   laser_cover_scorer_if.slave bus
);

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NPTS - 1);

   state_e           state_q, state_d;
   logic [2*CW-1:0]  bank_q [2][NPTS];
   logic [1:0]       full_q, full_d;
   logic             wr_bank_q;
   logic             last_fill_q;
   logic             rd_bank_q;
   logic [CNT_W-1:0] wr_cnt_q;
   logic [CNT_W-1:0] idx_q;
   logic [CW-1:0]    c1x_q, c1y_q, c2x_q, c2y_q;
   logic [CNT_W-1:0] cnt_c1_q, cnt_c2_q, cnt_both_q, cnt_total_q;
   logic             err_q;

   logic             fill_now;
   logic             any_full;
   logic             sel_bank;
   logic             start;
   logic             score_last;
   logic             wr_conflict;
   logic             done_err;
   logic [CW-1:0]    px, py;
   logic             hit1, hit2;

   // Event decode; a bank completing this cycle already counts as full for DONE
   always_comb begin
      fill_now    = bus.in_valid && (wr_cnt_q == LAST_IDX);
      any_full    = (|full_q) || fill_now;
      if (fill_now) begin
         sel_bank = wr_bank_q;
      end else if (full_q[last_fill_q]) begin
         sel_bank = last_fill_q;
      end else begin
         sel_bank = ~last_fill_q;
      end
      start       = (state_q == IDLE) && bus.done && any_full;
      score_last  = (state_q == SCORE) && (idx_q == LAST_IDX);
      wr_conflict = bus.in_valid && full_q[wr_bank_q];
      done_err    = bus.done && ((state_q != IDLE) || !any_full);
      {px, py}    = bank_q[rd_bank_q][idx_q];
   end

   circle_hit u_hit_c1 (
      .px  (px),
      .py  (py),
      .cx  (c1x_q),
      .cy  (c1y_q),
      .hit (hit1)
   );

   circle_hit u_hit_c2 (
      .px  (px),
      .py  (py),
      .cx  (c2x_q),
      .cy  (c2y_q),
      .hit (hit2)
   );

   // Full flags: a fill sets its bank, end of scoring releases the scored bank
   always_comb begin
      full_d = full_q;
      if (score_last) full_d[rd_bank_q] = 1'b0;
      if (fill_now)   full_d[wr_bank_q] = 1'b1;
   end

   // Load side: write every valid point, even into a still-full bank
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < NPTS; i++) begin
               bank_q[b][i] <= '0;
            end
         end
         full_q      <= '0;
         wr_bank_q   <= 1'b0;
         last_fill_q <= 1'b0;
         wr_cnt_q    <= '0;
      end else begin
         full_q <= full_d;
         if (bus.in_valid) begin
            bank_q[wr_bank_q][wr_cnt_q] <= {bus.x, bus.y};
            if (fill_now) begin
               wr_cnt_q    <= '0;
               wr_bank_q   <= ~wr_bank_q;
               last_fill_q <= wr_bank_q;
            end else begin
               wr_cnt_q <= wr_cnt_q + 1'b1;
            end
         end
      end
   end

   // Scoring datapath: latch centres on start, accumulate one point per cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_bank_q   <= 1'b0;
         idx_q       <= '0;
         c1x_q       <= '0;
         c1y_q       <= '0;
         c2x_q       <= '0;
         c2y_q       <= '0;
         cnt_c1_q    <= '0;
         cnt_c2_q    <= '0;
         cnt_both_q  <= '0;
         cnt_total_q <= '0;
      end else if (start) begin
         rd_bank_q   <= sel_bank;
         idx_q       <= '0;
         c1x_q       <= bus.c1x;
         c1y_q       <= bus.c1y;
         c2x_q       <= bus.c2x;
         c2y_q       <= bus.c2y;
         cnt_c1_q    <= '0;
         cnt_c2_q    <= '0;
         cnt_both_q  <= '0;
         cnt_total_q <= '0;
      end else if (state_q == SCORE) begin
         idx_q       <= score_last ? '0 : idx_q + 1'b1;
         cnt_c1_q    <= cnt_c1_q + CNT_W'(hit1);
         cnt_c2_q    <= cnt_c2_q + CNT_W'(hit2);
         cnt_both_q  <= cnt_both_q + CNT_W'(hit1 & hit2);
         cnt_total_q <= cnt_total_q + CNT_W'(hit1 | hit2);
      end
   end

   // Sticky protocol error, cleared only by reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_q | wr_conflict | done_err;
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state; DONE outside IDLE is ignored here and flagged via err
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = SCORE;
         SCORE:   if (score_last) state_d = HOLD;
         HOLD:    if (bus.res_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs: result is valid only while holding a finished score
   always_comb begin
      bus.res_valid = (state_q == HOLD);
      bus.cov_c1    = cnt_c1_q;
      bus.cov_c2    = cnt_c2_q;
      bus.cov_both  = cnt_both_q;
      bus.cov_total = cnt_total_q;
      bus.err       = err_q;
   end

endmodule

// File: tb/tb_laser_cover_scorer.sv
// Self-checking bench for laser_cover_scorer: table of uniform point sets,
// then hand-written sequences for errors, back-pressure and mid-score reset.
module tb_laser_cover_scorer;
   import laser_pkg::*;

   typedef struct {
      logic [3:0] px, py, c1x, c1y, c2x, c2y;
      int         e_c1, e_c2, e_both, e_total;
   } vec_t;

   typedef struct {
      int c1, c2, both, total;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   laser_cover_scorer_if bus ();

   laser_cover_scorer dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int         n_pass  = 0;
   int         n_total = 0;
   exp_t       sb[$];
   logic [3:0] pt_x [NPTS];
   logic [3:0] pt_y [NPTS];
   vec_t       tbl [6];

   task automatic chk(input string name, input int act, input int req);
      n_total++;
      if (act == req) n_pass++;
      else $display("FAIL %s: actual %0d required %0d", name, act, req);
   endtask

   task automatic do_reset();
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.x         = '0;
      bus.y         = '0;
      bus.done      = 1'b0;
      bus.c1x       = '0;
      bus.c1y       = '0;
      bus.c2x       = '0;
      bus.c2y       = '0;
      bus.res_ready = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      sb.delete();
   endtask

   task automatic fill_uniform(input logic [3:0] x, input logic [3:0] y);
      for (int i = 0; i < NPTS; i++) begin
         pt_x[i] = x;
         pt_y[i] = y;
      end
   endtask

   task automatic fill_ramp();
      for (int i = 0; i < NPTS; i++) begin
         pt_x[i] = 4'(i % 16);
         pt_y[i] = 4'd0;
      end
   endtask

   task automatic load_set();
      for (int i = 0; i < NPTS; i++) begin
         @(negedge clk);
         bus.in_valid = 1'b1;
         bus.x        = pt_x[i];
         bus.y        = pt_y[i];
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   // Pulse DONE, push the expectation, wait (bounded) for RES_VALID and compare.
   // redone_at > 0 re-pulses DONE that many cycles into SCORE.
   task automatic run_score(input string tag, input logic [3:0] c1x, input logic [3:0] c1y,
                            input logic [3:0] c2x, input logic [3:0] c2y, input exp_t e,
                            input int redone_at, input int exp_err);
      int   n;
      bit   got;
      exp_t r;
      @(negedge clk);
      bus.done = 1'b1;
      bus.c1x  = c1x;
      bus.c1y  = c1y;
      bus.c2x  = c2x;
      bus.c2y  = c2y;
      sb.push_back(e);
      n   = 0;
      got = 1'b0;
      while (!got && n < 200) begin
         @(negedge clk);
         bus.done = 1'b0;
         n++;
         if (n == redone_at) bus.done = 1'b1;
         if (bus.res_valid) got = 1'b1;
      end
      chk({tag, " latency"}, n, NPTS + 1);
      if (got && sb.size() > 0) begin
         r = sb.pop_front();
         chk({tag, " cov_c1"}, bus.cov_c1, r.c1);
         chk({tag, " cov_c2"}, bus.cov_c2, r.c2);
         chk({tag, " cov_both"}, bus.cov_both, r.both);
         chk({tag, " cov_total"}, bus.cov_total, r.total);
      end else begin
         chk({tag, " result_present"}, 0, 1);
      end
      chk({tag, " err"}, bus.err, exp_err);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      exp_t e;
      bit   seen;
      int   hold_req;

      tbl[0] = '{4'd8,  4'd8,  4'd8,  4'd8,  4'd0,  4'd0,  40, 0,  0,  40};
      tbl[1] = '{4'd4,  4'd0,  4'd0,  4'd0,  4'd8,  4'd0,  40, 40, 40, 40};
      tbl[2] = '{4'd3,  4'd3,  4'd0,  4'd0,  4'd15, 4'd15, 0,  0,  0,  0};
      tbl[3] = '{4'd15, 4'd15, 4'd15, 4'd15, 4'd12, 4'd15, 40, 40, 40, 40};
      tbl[4] = '{4'd0,  4'd0,  4'd15, 4'd15, 4'd0,  4'd4,  0,  40, 0,  40};
      tbl[5] = '{4'd5,  4'd5,  4'd2,  4'd2,  4'd7,  4'd7,  0,  40, 0,  40};

      // Reset state
      bus.in_valid  = 1'b0;
      bus.done      = 1'b0;
      bus.res_ready = 1'b1;
      #1;
      chk("reset res_valid", bus.res_valid, 0);
      chk("reset cov_c1", bus.cov_c1, 0);
      chk("reset cov_total", bus.cov_total, 0);
      chk("reset err", bus.err, 0);
      do_reset();

      // Uniform sets, including exact-radius and just-outside boundaries
      for (int v = 0; v < 6; v++) begin
         fill_uniform(tbl[v].px, tbl[v].py);
         load_set();
         e = '{tbl[v].e_c1, tbl[v].e_c2, tbl[v].e_both, tbl[v].e_total};
         run_score($sformatf("vec%0d", v), tbl[v].c1x, tbl[v].c1y, tbl[v].c2x, tbl[v].c2y,
                   e, 0, 0);
      end

      // DONE with no full bank
      do_reset();
      @(negedge clk);
      bus.done = 1'b1;
      @(negedge clk);
      bus.done = 1'b0;
      chk("early_done err", bus.err, 1);
      seen = 1'b0;
      repeat (50) begin
         @(negedge clk);
         if (bus.res_valid) seen = 1'b1;
      end
      chk("early_done no_result", seen, 0);

      // DONE during SCORE: flagged, running result untouched
      do_reset();
      fill_uniform(4'd8, 4'd8);
      load_set();
      run_score("redone", 4'd8, 4'd8, 4'd0, 4'd0, '{40, 0, 0, 40}, 10, 1);

      // Back-pressure in HOLD while the next set loads into the other bank
      do_reset();
      fill_uniform(4'd8, 4'd8);
      load_set();
      bus.res_ready = 1'b0;
      run_score("hold_a", 4'd8, 4'd8, 4'd0, 4'd0, '{40, 0, 0, 40}, 0, 0);
      fill_ramp();
      hold_req = int'({1'b1, 6'd40, 6'd0, 6'd0, 6'd40});
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (k < NPTS) begin
            bus.in_valid = 1'b1;
            bus.x        = pt_x[k];
            bus.y        = pt_y[k];
         end else begin
            bus.in_valid = 1'b0;
         end
         chk($sformatf("hold_stable k%0d", k),
             int'({bus.res_valid, bus.cov_c1, bus.cov_c2, bus.cov_both, bus.cov_total}),
             hold_req);
      end
      chk("hold_load err", bus.err, 0);
      bus.in_valid  = 1'b0;
      bus.res_ready = 1'b1;
      @(negedge clk);
      chk("hold_release res_valid", bus.res_valid, 0);
      run_score("ramp_b", 4'd2, 4'd0, 4'd6, 4'd0, '{21, 24, 15, 30}, 0, 0);

      // Asynchronous reset in the middle of SCORE
      do_reset();
      fill_uniform(4'd8, 4'd8);
      load_set();
      @(negedge clk);
      bus.done = 1'b1;
      bus.c1x  = 4'd8;
      bus.c1y  = 4'd8;
      bus.c2x  = 4'd0;
      bus.c2y  = 4'd0;
      @(negedge clk);
      bus.done = 1'b0;
      repeat (20) @(negedge clk);
      chk("mid_score cov_c1", bus.cov_c1, 20);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst res_valid", bus.res_valid, 0);
      chk("async_rst cov_c1", bus.cov_c1, 0);
      chk("async_rst cov_total", bus.cov_total, 0);
      chk("async_rst err", bus.err, 0);
      @(negedge clk);
      rst_n = 1'b1;
      sb.delete();
      fill_uniform(4'd5, 4'd5);
      load_set();
      run_score("post_rst", 4'd2, 4'd2, 4'd7, 4'd7, '{0, 40, 0, 40}, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
